multi_lane_cdb: RTL

MULTI_LANE_CDB -- requirements
Module: multi_lane_cdb

---
 rtl/multi_lane_cdb.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_lane_cdb.sv
// multi_lane_cdb: multi-lane common data bus.
//
// Result issuers are split by ISSUER_ARCH_REG into two independently arbitrated
// round-robin pools. The ROB pool grants up to LANES issuers per cycle; the k-th
// grant drives lane k. The arch pool grants at most one issuer per cycle and
// drives the single arch register write port. Granted payloads are registered,
// so they appear on the outputs for exactly one cycle after the grant.
// Reservation-station listeners snoop the registered ROB lanes combinationally.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   flush             suppresses all grants; the registered outputs clear on the next edge
//   cdb_isr_*         issuer side: request/grant handshake with data, ROB tag and arch index
//   rob_*             registered ROB broadcast lanes (valid, tag, data)
//   arch_reg_*        registered arch register write (enable, index, data)
//   cdb_lsn_*         listener side: awaited tag in; hit and matched data out

module multi_lane_cdb #(
  parameter int unsigned ISSUER     = 4,
  parameter int unsigned LISTENER   = 4,
  parameter int unsigned LANES      = 2,
  parameter int unsigned ROB_ENTRY  = 4,
  parameter int unsigned ARCH_ENTRY = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ISSUER-1:0] ISSUER_ARCH_REG = {1'd0, 1'd0, 1'd0, 1'd1},
  localparam int unsigned ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
  localparam int unsigned ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                flush,
  input  logic [ISSUER-1:0]                   cdb_isr_request,
  output logic [ISSUER-1:0]                   cdb_isr_grant,
  input  logic [ISSUER*DATA_WIDTH-1:0]        cdb_isr_data,
  input  logic [ISSUER*ROB_ENTRY_LOG2-1:0]    cdb_isr_id,
  input  logic [ISSUER*ARCH_ENTRY_LOG2-1:0]   cdb_isr_arch_id,
  output logic [LANES-1:0]                    rob_write,
  output logic [LANES*ROB_ENTRY_LOG2-1:0]     rob_id,
  output logic [LANES*DATA_WIDTH-1:0]         rob_data,
  output logic                                arch_reg_write,
  output logic [ARCH_ENTRY_LOG2-1:0]          arch_reg_id,
  output logic [DATA_WIDTH-1:0]               arch_reg_data,
  input  logic [LISTENER-1:0]                 cdb_lsn_request,
  input  logic [LISTENER*ROB_ENTRY_LOG2-1:0]  cdb_lsn_id,
  output logic [LISTENER-1:0]                 cdb_lsn_hit,
  output logic [LISTENER*DATA_WIDTH-1:0]      cdb_lsn_data
);

  localparam int unsigned RW    = ROB_ENTRY_LOG2;
  localparam int unsigned AW    = ARCH_ENTRY_LOG2;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PTR_W = (ISSUER > 1) ? $clog2(ISSUER) : 1;

  // (base + off) mod ISSUER; base < ISSUER and off < ISSUER, so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_idx(logic [PTR_W-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= ISSUER) s = s - ISSUER;
    return PTR_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] last);
    return (last == PTR_W'(ISSUER - 1)) ? '0 : last + 1'b1;
  endfunction

  // Round-robin pointers
  logic [PTR_W-1:0] rob_ptr_q, rob_ptr_d;
  logic [PTR_W-1:0] arch_ptr_q, arch_ptr_d;

  // Registered broadcast state
  logic [LANES-1:0]    rob_write_q, rob_write_d;
  logic [LANES*RW-1:0] rob_id_q, rob_id_d;
  logic [LANES*DW-1:0] rob_data_q, rob_data_d;
  logic                arch_write_q, arch_write_d;
  logic [AW-1:0]       arch_id_q, arch_id_d;
  logic [DW-1:0]       arch_data_q, arch_data_d;

  // Scan order of each pool, starting at its pointer
  logic [PTR_W-1:0] rob_scan  [ISSUER];
  logic [PTR_W-1:0] arch_scan [ISSUER];

  always_comb begin
    for (int i = 0; i < ISSUER; i++) begin
      rob_scan[i]  = wrap_idx(rob_ptr_q, i);
      arch_scan[i] = wrap_idx(arch_ptr_q, i);
    end
  end

  // Requests eligible in each pool
  logic [ISSUER-1:0] rob_elig, arch_elig;
  assign rob_elig  = cdb_isr_request & ~ISSUER_ARCH_REG;
  assign arch_elig = cdb_isr_request & ISSUER_ARCH_REG;

  // Arbitration and next-state of the broadcast registers
  logic [ISSUER-1:0] grant;
  logic [PTR_W-1:0]  lane_sel [LANES];
  logic [PTR_W-1:0]  rob_last, arch_sel;
  int unsigned       rob_cnt;
  logic              arch_found;

  always_comb begin
    grant        = '0;
    rob_write_d  = '0;
    rob_id_d     = '0;
    rob_data_d   = '0;
    arch_write_d = 1'b0;
    arch_id_d    = '0;
    arch_data_d  = '0;
    rob_ptr_d    = rob_ptr_q;
    arch_ptr_d   = arch_ptr_q;
    rob_cnt      = 0;
    rob_last     = '0;
    arch_found   = 1'b0;
    arch_sel     = '0;
    for (int l = 0; l < LANES; l++) lane_sel[l] = '0;

    // Reset and flush both silence the bus; pointers only move on real grants.
    if (!RST && !flush) begin
      // ROB pool: walk from the pointer, filling lanes in grant order.
      for (int i = 0; i < ISSUER; i++) begin
        if (rob_elig[rob_scan[i]] && (rob_cnt < LANES)) begin
          for (int l = 0; l < LANES; l++) begin
            if (rob_cnt == l) begin
              rob_write_d[l] = 1'b1;
              lane_sel[l]    = rob_scan[i];
            end
          end
          grant[rob_scan[i]] = 1'b1;
          rob_last           = rob_scan[i];
          rob_cnt            = rob_cnt + 1;
        end
      end
      if (rob_cnt != 0) rob_ptr_d = next_ptr(rob_last);

      for (int l = 0; l < LANES; l++) begin
        if (rob_write_d[l]) begin
          rob_id_d[l*RW +: RW]   = cdb_isr_id[lane_sel[l]*RW +: RW];
          rob_data_d[l*DW +: DW] = cdb_isr_data[lane_sel[l]*DW +: DW];
        end
      end

      // Arch pool: first eligible issuer from the pointer wins.
      for (int i = 0; i < ISSUER; i++) begin
        if (arch_elig[arch_scan[i]] && !arch_found) begin
          arch_found = 1'b1;
          arch_sel   = arch_scan[i];
        end
      end
      if (arch_found) begin
        grant[arch_sel] = 1'b1;
        arch_write_d    = 1'b1;
        arch_id_d       = cdb_isr_arch_id[arch_sel*AW +: AW];
        arch_data_d     = cdb_isr_data[arch_sel*DW +: DW];
        arch_ptr_d      = next_ptr(arch_sel);
      end
    end
  end

  assign cdb_isr_grant = grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rob_ptr_q    <= '0;
      arch_ptr_q   <= '0;
      rob_write_q  <= '0;
      rob_id_q     <= '0;
      rob_data_q   <= '0;
      arch_write_q <= 1'b0;
      arch_id_q    <= '0;
      arch_data_q  <= '0;
    end else begin
      rob_ptr_q    <= rob_ptr_d;
      arch_ptr_q   <= arch_ptr_d;
      rob_write_q  <= rob_write_d;
      rob_id_q     <= rob_id_d;
      rob_data_q   <= rob_data_d;
      arch_write_q <= arch_write_d;
      arch_id_q    <= arch_id_d;
      arch_data_q  <= arch_data_d;
    end
  end

  assign rob_write      = rob_write_q;
  assign rob_id         = rob_id_q;
  assign rob_data       = rob_data_q;
  assign arch_reg_write = arch_write_q;
  assign arch_reg_id    = arch_id_q;
  assign arch_reg_data  = arch_data_q;

  // Listener snoop: scanning lanes high-to-low lets the lowest matching lane win.
  always_comb begin
    cdb_lsn_hit  = '0;
    cdb_lsn_data = '0;
    for (int g = 0; g < LISTENER; g++) begin
      for (int l = LANES - 1; l >= 0; l--) begin
        if (cdb_lsn_request[g] && rob_write_q[l] &&
            (rob_id_q[l*RW +: RW] == cdb_lsn_id[g*RW +: RW])) begin
          cdb_lsn_hit[g]              = 1'b1;
          cdb_lsn_data[g*DW +: DW]    = rob_data_q[l*DW +: DW];
        end
      end
    end
  end

endmodule
